// File: rtl/cmsdk_ahb_to_ahb_apb_async_sync_bus.sv
`default_nettype none
// ============================================================================
// Module   : cmsdk_ahb_to_ahb_apb_async_sync_bus
// Purpose  : Multi-bit, multi-stage CDC level synchroniser with per-bit
//            RISE/FALL/EDGE pulse generation. Each bit is an independent
//            channel; there is no coherency between bits.
// Options  : `define CMSDK_SYNC_BUS_STABLE_EN adds a per-channel glitch
//            filter requiring STABLE_CYCLES consecutive new values.
// Revision : 1.0 - initial release
// ============================================================================
module cmsdk_ahb_to_ahb_apb_async_sync_bus #(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}},
  parameter int               STABLE_CYCLES = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic [WIDTH-1:0] EDGE
);

`ifdef CMSDK_SYNC_BUS_STABLE_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  // Illegal configurations stop elaboration; STABLE_CYCLES only matters
  // when the filter is built.
  if (WIDTH < 1 || STAGES < 2 || (FILTER_EN && STABLE_CYCLES < 1)) begin : g_param_err
    $fatal(1, "cmsdk_ahb_to_ahb_apb_async_sync_bus: illegal WIDTH/STAGES/STABLE_CYCLES");
  end

  // Synchroniser chain: index 0 captures D, index STAGES-1 is the output.
  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;
  logic [WIDTH-1:0]             sync_out;
  logic [WIDTH-1:0]             v;
  logic [WIDTH-1:0]             prev_q;
  logic [WIDTH-1:0]             prev_d;

  // Shift every channel one stage deeper per clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], D};
  end

  // Chain flops, asynchronously forced to the reset level.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[STAGES-1];

`ifdef CMSDK_SYNC_BUS_STABLE_EN
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [WIDTH-1:0]            filt_q;
  logic [WIDTH-1:0]            filt_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;

  // Accept a new level only after it has differed from the filtered value
  // for STABLE_CYCLES consecutive clocks; any return restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_out[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(STABLE_CYCLES - 1)) begin
        filt_d[i] = sync_out[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Filter state flops.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      filt_q <= RESET_VAL;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign v = filt_q;
`else
  assign v = sync_out;
`endif

  // Previous qualified value, used for edge detection.
  always_comb begin
    prev_d = v;
  end

  // Previous-value register; equals v during reset so no pulse can appear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign Q    = v;
  assign RISE = v & ~prev_q;
  assign FALL = ~v & prev_q;
  assign EDGE = v ^ prev_q;

endmodule
`default_nettype wire

// File: tb/tb_cmsdk_ahb_to_ahb_apb_async_sync_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmsdk_ahb_to_ahb_apb_async_sync_bus
// Purpose  : Self-checking bench: directed and random stimulus compared
//            against a history-based reference model of the synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmsdk_ahb_to_ahb_apb_async_sync_bus;

  localparam int         W  = 4;
  localparam int         S  = 3;
  localparam int         SC = 3;
  localparam logic [W-1:0] RV = 4'b1010;

  logic         CLK   = 1'b0;
  logic         RESET = 1'b1;
  logic [W-1:0] D     = RV;
  logic [W-1:0] Q;
  logic [W-1:0] RISE;
  logic [W-1:0] FALL;
  logic [W-1:0] EDGE;

  cmsdk_ahb_to_ahb_apb_async_sync_bus #(
    .WIDTH         (W),
    .STAGES        (S),
    .RESET_VAL     (RV),
    .STABLE_CYCLES (SC)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .D     (D),
    .Q     (Q),
    .RISE  (RISE),
    .FALL  (FALL),
    .EDGE  (EDGE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // dh[e]: D level sampled at edge e since reset release (1-based).
  // vh[e]: expected qualified level after edge e; vh[0] is the reset level.
  logic [W-1:0] dh [0:4095];
  logic [W-1:0] vh [0:4095];
  int           n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", tag, obs, exp, n, $time);
    end
  endtask

  // Synchroniser output after edge e: the D level captured S-1 edges earlier,
  // or the reset level if the chain has not yet been filled since reset.
  function automatic logic [W-1:0] sync_at(input int e);
    if (e >= S) return dh[e-S+1];
    return RV;
  endfunction

  // Qualified level after edge e.
  function automatic logic [W-1:0] model_v(input int e);
    logic [W-1:0] f;
`ifdef CMSDK_SYNC_BUS_STABLE_EN
    f = vh[e-1];
    for (int b = 0; b < W; b++) begin
      bit flip;
      flip = 1'b1;
      for (int k = 1; k <= SC; k++) begin
        logic [W-1:0] s;
        s = sync_at(e - k);
        if (s[b] == f[b]) flip = 1'b0;
      end
      if (flip) f[b] = ~f[b];
    end
`else
    f = sync_at(e);
`endif
    return f;
  endfunction

  // Drive one D value for the next edge, then check all outputs mid-cycle.
  task automatic step(input logic [W-1:0] d);
    logic [W-1:0] cur;
    logic [W-1:0] prv;
    D = d;
    @(posedge CLK);
    n++;
    dh[n] = d;
    vh[n] = model_v(n);
    @(negedge CLK);
    cur = vh[n];
    prv = vh[n-1];
    check("q",    {28'd0, Q},    {28'd0, cur});
    check("rise", {28'd0, RISE}, {28'd0, cur & ~prv});
    check("fall", {28'd0, FALL}, {28'd0, ~cur & prv});
    check("edge", {28'd0, EDGE}, {28'd0, cur ^ prv});
  endtask

  task automatic check_reset_outputs();
    check("rst_q",     {28'd0, Q},    {28'd0, RV});
    check("rst_rise",  {28'd0, RISE}, 32'd0);
    check("rst_fall",  {28'd0, FALL}, 32'd0);
    check("rst_edge",  {28'd0, EDGE}, 32'd0);
  endtask

  // Assert reset between clock edges, check immediate effect, release at a
  // falling edge so the next rising edge is edge 1.
  task automatic async_reset(input logic [W-1:0] d_hold);
    #2;
    RESET = 1'b1;
    D     = d_hold;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge CLK);
    check_reset_outputs();
    RESET = 1'b0;
    n     = 0;
    vh[0] = RV;
  endtask

  initial begin
    logic [W-1:0] mask;
    n     = 0;
    vh[0] = RV;

    // Reset held with D at the reset level.
    repeat (3) @(negedge CLK);
    check_reset_outputs();
    RESET = 1'b0;

    // No pulses for 10 cycles while D equals RESET_VAL.
    for (int i = 0; i < 10; i++) step(RV);

    // Mixed rise/fall on different bits.
    for (int i = 0; i < 6; i++) step(4'b0110);

    // Toggle every bit every cycle, then hold.
    for (int i = 0; i < 8; i++) step(~D);
    for (int i = 0; i < 6; i++) step(D);

    // Reset mid-propagation, D held high through release.
    step(4'b1111);
    step(4'b1111);
    async_reset(4'b1111);
    for (int i = 0; i < 8; i++) step(4'b1111);

    // Short pulses against the filter (or straight through without it).
    step(4'b0000);
    for (int i = 0; i < 6; i++) step(4'b0000);
    step(4'b0101);
    step(4'b0101);
    for (int i = 0; i < 6; i++) step(4'b0000);

    // Random: sparse bit flips with held intervals and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset(W'($urandom));
      end else begin
        mask = W'($urandom) & W'($urandom) & W'($urandom);
        step(D ^ mask);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
